pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage MIPS pipeline. It computes operand-forwarding selects for ID-stage consumers from EX/MEM/WB producers. It sequences pipeline stalls for load-use and HI/LO multiply/divide-unit (MDU) hazards, and flushes IF/ID on taken branches. It drives the load-enables of PC and IF/ID and the bubble-insert of ID/EX, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
MDU_LAT, 4, cycles from mdu_start until HI/LO results are valid (2..15)
STAT_W, 16, width of the stall statistics counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high reset
rs_ID  in  5  source register rs of instruction in ID
rt_ID  in  5  source register rt of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_uses_hilo  in  1  ID instruction is MFHI/MFLO
branch_taken_ID  in  1  branch/jump resolved taken in ID
WriteDestination_EX  in  5  destination register of EX instruction
ex_regwrite  in  1  EX instruction writes register file
ex_load  in  1  EX instruction is a load
mdu_start  in  1  EX instruction launches MULT/DIV this cycle
WriteDestination_MEM  in  5  destination register in MEM
mem_regwrite  in  1  MEM instruction writes register file
WriteDestination_WB  in  5  destination register in WB
wb_regwrite  in  1  WB instruction writes register file
pc_le  out  1  PC load enable
if_id_le  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID load NOP next edge
id_ex_bubble  out  1  ID/EX load all-zero control next edge
fwd_a_sel  out  2  rs operand select: 0 regfile, 1 EX ALU out, 2 MEM out, 3 WB out
fwd_b_sel  out  2  rt operand select, same encoding
mdu_busy  out  1  MDU result not yet valid
stall_cycles  out  STAT_W  count of cycles with pc_le=0

Behaviour:
- State: FSM {RUN, MDU_BUSY}, 4-bit mdu_cnt, stall_cycles register. Outputs are combinational from state and inputs.
- Reset: state=RUN, mdu_cnt=0, stall_cycles=0. This gives pc_le=1, if_id_le=1, if_id_flush=0, id_ex_bubble=0, mdu_busy=0, fwd selects=0, provided the inputs are idle. Reset mid-MDU aborts the wait immediately.
- Forwarding, per operand (rs→a, rt→b): a source of register 0 or an unused source → 0.
  - Else priority EX(1) > MEM(2) > WB(3) on match of WriteDestination_x with regwrite_x=1. Else 0.
  - An EX match with ex_load=1 never selects 1; it raises a load-use stall instead.
- load_use = ex_load & ex_regwrite & WriteDestination_EX!=0 & ((id_uses_rs & rs match) | (id_uses_rt & rt match)).
- hilo_stall = mdu_busy & id_uses_hilo.
- stall = load_use | hilo_stall.
  - When stall=1: pc_le=0, if_id_le=0, id_ex_bubble=1, if_id_flush=0.
  - A load-use stall lasts exactly 1 cycle; next cycle the load is in MEM and forwarding select 2 applies.
- Flush: if_id_flush = branch_taken_ID & ~stall. Stall has priority; the branch re-resolves after the stall.
- MDU sequencing:
  - RUN + mdu_start → MDU_BUSY, mdu_cnt=MDU_LAT-1.
  - In MDU_BUSY: mdu_cnt decrements each cycle; at mdu_cnt==1 the next state is RUN with mdu_cnt=0.
  - mdu_start while in MDU_BUSY reloads mdu_cnt=MDU_LAT-1.
  - mdu_busy = (state==MDU_BUSY).
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones.
- Simultaneous load_use and hilo_stall: a single stall is asserted and counted once.

Decomposition:
- Package hazard_pkg: FWD_REGFILE=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3; FSM state encoding (RUN=0, MDU_BUSY=1).
- Sub-module fwd_select (combinational priority compare for one operand), instantiated twice (rs, rt).

Test Plan:
- Reset held 2 cycles, then idle inputs → pc_le=1, if_id_le=1, bubble=0, flush=0, fwd_a_sel=fwd_b_sel=0, stall_cycles=0.
- EX ADD writes $5 (ex_regwrite=1), ID reads rs=$5, rt=$5; MEM also writes $5 → fwd_a_sel=1, fwd_b_sel=1 (EX priority). With only WB writing $5 → both 3. With rs=$0 and all stages writing $0 → 0.
- EX LW to $8, ID rs=$8 → exactly one cycle pc_le=0, if_id_le=0, id_ex_bubble=1, stall_cycles=1. Next cycle (load in MEM) → stall=0, fwd_a_sel=2.
- mdu_start pulse with MDU_LAT=4, ID MFLO held → mdu_busy=1 and stall=1 for 3 cycles, then pc_le=1. A second mdu_start during the busy window extends the wait to 3 cycles from the restart.
- branch_taken_ID=1 with no hazard → if_id_flush=1 for that cycle. Branch together with load-use → flush=0, stall=1; next cycle flush=1.
- Force 2^16+5 stall cycles → stall_cycles saturates at 16'hFFFF. Assert reset during MDU_BUSY → next cycle mdu_busy=0 and stall_cycles=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EX      = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;
  localparam logic [1:0] FWD_WB      = 2'd3;

  typedef enum logic {
    StRun     = 1'b0,
    StMduBusy = 1'b1
  } hz_state_e;

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding select for one ID-stage source operand (EX > MEM > WB).
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       used_i,
  input  logic [4:0] ex_dst_i,
  input  logic       ex_regwrite_i,
  input  logic       ex_load_i,
  input  logic [4:0] mem_dst_i,
  input  logic       mem_regwrite_i,
  input  logic [4:0] wb_dst_i,
  input  logic       wb_regwrite_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_REGFILE;
    if (used_i && (src_i != 5'd0)) begin
      if (ex_regwrite_i && (ex_dst_i == src_i)) begin
        // Load data is not ready in EX; the controller stalls and older stages are stale.
        sel_o = ex_load_i ? FWD_REGFILE : FWD_EX;
      end else if (mem_regwrite_i && (mem_dst_i == src_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_regwrite_i && (wb_dst_i == src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding, load-use/HI-LO stalls,
// branch flush and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs_ID,
  input  logic [4:0]        rt_ID,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_uses_hilo,
  input  logic              branch_taken_ID,
  input  logic [4:0]        WriteDestination_EX,
  input  logic              ex_regwrite,
  input  logic              ex_load,
  input  logic              mdu_start,
  input  logic [4:0]        WriteDestination_MEM,
  input  logic              mem_regwrite,
  input  logic [4:0]        WriteDestination_WB,
  input  logic              wb_regwrite,
  output logic              pc_le,
  output logic              if_id_le,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              mdu_busy,
  output logic [STAT_W-1:0] stall_cycles
);

  localparam logic [3:0] MduReload = 4'(MDU_LAT - 1);

  hz_state_e         state_q, state_d;
  logic [3:0]        mdu_cnt_q, mdu_cnt_d;
  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic load_use, hilo_stall, stall;

  fwd_select u_fwd_a (
    .src_i          (rs_ID),
    .used_i         (id_uses_rs),
    .ex_dst_i       (WriteDestination_EX),
    .ex_regwrite_i  (ex_regwrite),
    .ex_load_i      (ex_load),
    .mem_dst_i      (WriteDestination_MEM),
    .mem_regwrite_i (mem_regwrite),
    .wb_dst_i       (WriteDestination_WB),
    .wb_regwrite_i  (wb_regwrite),
    .sel_o          (fwd_a_sel)
  );

  fwd_select u_fwd_b (
    .src_i          (rt_ID),
    .used_i         (id_uses_rt),
    .ex_dst_i       (WriteDestination_EX),
    .ex_regwrite_i  (ex_regwrite),
    .ex_load_i      (ex_load),
    .mem_dst_i      (WriteDestination_MEM),
    .mem_regwrite_i (mem_regwrite),
    .wb_dst_i       (WriteDestination_WB),
    .wb_regwrite_i  (wb_regwrite),
    .sel_o          (fwd_b_sel)
  );

  always_comb begin
    load_use = ex_load && ex_regwrite && (WriteDestination_EX != 5'd0) &&
               ((id_uses_rs && (rs_ID == WriteDestination_EX)) ||
                (id_uses_rt && (rt_ID == WriteDestination_EX)));
    mdu_busy     = (state_q == StMduBusy);
    hilo_stall   = mdu_busy && id_uses_hilo;
    stall        = load_use || hilo_stall;
    pc_le        = ~stall;
    if_id_le     = ~stall;
    id_ex_bubble = stall;
    // A stalled branch stays in ID and re-resolves once the stall clears.
    if_id_flush  = branch_taken_ID && ~stall;
    stall_cycles = stall_cycles_q;
  end

  always_comb begin
    state_d        = state_q;
    mdu_cnt_d      = mdu_cnt_q;
    stall_cycles_d = stall_cycles_q;
    unique case (state_q)
      StRun: begin
        if (mdu_start) begin
          state_d   = StMduBusy;
          mdu_cnt_d = MduReload;
        end
      end
      StMduBusy: begin
        if (mdu_start) begin
          mdu_cnt_d = MduReload;
        end else if (mdu_cnt_q <= 4'd1) begin
          state_d   = StRun;
          mdu_cnt_d = 4'd0;
        end else begin
          mdu_cnt_d = mdu_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d   = StRun;
        mdu_cnt_d = 4'd0;
      end
    endcase
    if (stall && (stall_cycles_q != {STAT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      mdu_cnt_q      <= 4'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mdu_cnt_q      <= mdu_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: table of single-cycle vectors plus
// hand-written multi-cycle sequences (load-use, MDU wait, branch, saturation, reset).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_ID, rt_ID;
  logic        id_uses_rs, id_uses_rt, id_uses_hilo, branch_taken_ID;
  logic [4:0]  WriteDestination_EX, WriteDestination_MEM, WriteDestination_WB;
  logic        ex_regwrite, ex_load, mdu_start, mem_regwrite, wb_regwrite;
  logic        pc_le, if_id_le, if_id_flush, id_ex_bubble, mdu_busy;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MDU_LAT(4), .STAT_W(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .rs_ID                (rs_ID),
    .rt_ID                (rt_ID),
    .id_uses_rs           (id_uses_rs),
    .id_uses_rt           (id_uses_rt),
    .id_uses_hilo         (id_uses_hilo),
    .branch_taken_ID      (branch_taken_ID),
    .WriteDestination_EX  (WriteDestination_EX),
    .ex_regwrite          (ex_regwrite),
    .ex_load              (ex_load),
    .mdu_start            (mdu_start),
    .WriteDestination_MEM (WriteDestination_MEM),
    .mem_regwrite         (mem_regwrite),
    .WriteDestination_WB  (WriteDestination_WB),
    .wb_regwrite          (wb_regwrite),
    .pc_le                (pc_le),
    .if_id_le             (if_id_le),
    .if_id_flush          (if_id_flush),
    .id_ex_bubble         (id_ex_bubble),
    .fwd_a_sel            (fwd_a_sel),
    .fwd_b_sel            (fwd_b_sel),
    .mdu_busy             (mdu_busy),
    .stall_cycles         (stall_cycles)
  );

  // Expected packing: {pc_le, if_id_le, if_id_flush, id_ex_bubble, fwd_a_sel, fwd_b_sel}
  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       urs, urt, br;
    logic [4:0] exd;
    logic       exw, exl;
    logic [4:0] memd;
    logic       memw;
    logic [4:0] wbd;
    logic       wbw;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [4:0] rs, logic [4:0] rt, logic urs,
                              logic urt, logic br, logic [4:0] exd, logic exw, logic exl,
                              logic [4:0] memd, logic memw, logic [4:0] wbd, logic wbw,
                              logic [7:0] exp);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br;
    v.exd = exd; v.exw = exw; v.exl = exl; v.memd = memd; v.memw = memw;
    v.wbd = wbd; v.wbw = wbw; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {pc_le, if_id_le, if_id_flush, id_ex_bubble, fwd_a_sel, fwd_b_sel};
  endfunction

  task automatic set_idle();
    rs_ID = 5'd0; rt_ID = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_uses_hilo = 1'b0; branch_taken_ID = 1'b0; mdu_start = 1'b0;
    WriteDestination_EX = 5'd0; ex_regwrite = 1'b0; ex_load = 1'b0;
    WriteDestination_MEM = 5'd0; mem_regwrite = 1'b0;
    WriteDestination_WB = 5'd0; wb_regwrite = 1'b0;
  endtask

  // Advance one clock; inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_idle();

    vecs.push_back(mk("idle",         0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 8'hC0));
    vecs.push_back(mk("ex_over_mem",  5, 5, 1, 1, 0,  5, 1, 0,  5, 1,  0, 0, 8'hC5));
    vecs.push_back(mk("wb_only",      5, 5, 1, 1, 0,  0, 0, 0,  0, 0,  5, 1, 8'hCF));
    vecs.push_back(mk("reg_zero",     0, 0, 1, 1, 0,  0, 1, 0,  0, 1,  0, 1, 8'hC0));
    vecs.push_back(mk("mem_a_wb_b",   7, 3, 1, 1, 0,  0, 0, 0,  7, 1,  3, 1, 8'hCB));
    vecs.push_back(mk("rs_unused",    5, 5, 0, 1, 0,  5, 1, 0,  0, 0,  0, 0, 8'hC1));
    vecs.push_back(mk("ex_no_wr",     5, 0, 1, 0, 0,  5, 0, 0,  5, 1,  0, 0, 8'hC8));
    vecs.push_back(mk("branch",       0, 0, 0, 0, 1,  0, 0, 0,  0, 0,  0, 0, 8'hE0));
    vecs.push_back(mk("load_use_rs",  8, 0, 1, 0, 0,  8, 1, 1,  0, 0,  0, 0, 8'h10));
    vecs.push_back(mk("ld_rt_branch", 0, 9, 0, 1, 1,  9, 1, 1,  0, 0,  0, 0, 8'h10));
    vecs.push_back(mk("load_r0",      0, 0, 1, 0, 0,  0, 1, 1,  0, 0,  0, 0, 8'hC0));
    vecs.push_back(mk("load_unused",  8, 0, 0, 0, 0,  8, 1, 1,  0, 0,  0, 0, 8'hC0));

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_outs", {24'd0, outs()}, 32'hC0);
    check("reset_busy", {31'd0, mdu_busy}, 32'd0);
    check("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    tick();

    // Table of single-cycle vectors
    foreach (vecs[i]) begin
      rs_ID = vecs[i].rs; rt_ID = vecs[i].rt;
      id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt; branch_taken_ID = vecs[i].br;
      WriteDestination_EX = vecs[i].exd; ex_regwrite = vecs[i].exw; ex_load = vecs[i].exl;
      WriteDestination_MEM = vecs[i].memd; mem_regwrite = vecs[i].memw;
      WriteDestination_WB = vecs[i].wbd; wb_regwrite = vecs[i].wbw;
      @(negedge clk);
      check(vecs[i].name, {24'd0, outs()}, {24'd0, vecs[i].exp});
      tick();
    end
    set_idle();
    #1;
    check("table_stall_cycles", {16'd0, stall_cycles}, 32'd2);

    // Load-use: one stall, then the load forwards from MEM
    do_reset();
    rs_ID = 5'd8; id_uses_rs = 1'b1;
    WriteDestination_EX = 5'd8; ex_regwrite = 1'b1; ex_load = 1'b1;
    @(negedge clk);
    check("lu_stall", {24'd0, outs()}, 32'h10);
    tick();
    WriteDestination_EX = 5'd0; ex_regwrite = 1'b0; ex_load = 1'b0;
    WriteDestination_MEM = 5'd8; mem_regwrite = 1'b1;
    @(negedge clk);
    check("lu_after_mem_fwd", {24'd0, outs()}, 32'hC8);
    check("lu_stall_cycles", {16'd0, stall_cycles}, 32'd1);
    tick();
    set_idle();

    // Branch together with load-use: flush waits one cycle
    rs_ID = 5'd4; id_uses_rs = 1'b1; branch_taken_ID = 1'b1;
    WriteDestination_EX = 5'd4; ex_regwrite = 1'b1; ex_load = 1'b1;
    @(negedge clk);
    check("br_lu_stall", {24'd0, outs()}, 32'h10);
    tick();
    WriteDestination_EX = 5'd0; ex_regwrite = 1'b0; ex_load = 1'b0;
    WriteDestination_MEM = 5'd4; mem_regwrite = 1'b1;
    @(negedge clk);
    check("br_lu_flush_next", {24'd0, outs()}, 32'hE8);
    tick();
    set_idle();

    // MDU wait with MFLO held in ID
    do_reset();
    id_uses_hilo = 1'b1; mdu_start = 1'b1;
    @(negedge clk);
    check("mdu_start_cycle", {30'd0, mdu_busy, pc_le}, 32'd1);
    tick();
    mdu_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("mdu_wait_%0d", c), {30'd0, mdu_busy, pc_le}, 32'd2);
      tick();
    end
    @(negedge clk);
    check("mdu_done", {30'd0, mdu_busy, pc_le}, 32'd1);
    check("mdu_stall_cycles", {16'd0, stall_cycles}, 32'd3);
    tick();

    // MDU restart mid-wait: three more busy cycles after the restart
    do_reset();
    mdu_start = 1'b1;
    tick();
    mdu_start = 1'b0;
    tick();
    mdu_start = 1'b1;
    @(negedge clk);
    check("mdu_restart_busy", {31'd0, mdu_busy}, 32'd1);
    tick();
    mdu_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("mdu_ext_%0d", c), {31'd0, mdu_busy}, 32'd1);
      tick();
    end
    @(negedge clk);
    check("mdu_ext_done", {31'd0, mdu_busy}, 32'd0);

    // Load-use and HI/LO stall together count once
    do_reset();
    mdu_start = 1'b1;
    tick();
    mdu_start = 1'b0;
    id_uses_hilo = 1'b1; rs_ID = 5'd6; id_uses_rs = 1'b1;
    WriteDestination_EX = 5'd6; ex_regwrite = 1'b1; ex_load = 1'b1;
    @(negedge clk);
    check("dual_stall_outs", {24'd0, outs()}, 32'h10);
    tick();
    set_idle();
    #1;
    check("dual_stall_count", {16'd0, stall_cycles}, 32'd1);

    // Reset during MDU_BUSY aborts the wait and clears the counter
    do_reset();
    id_uses_hilo = 1'b1; mdu_start = 1'b1;
    tick();
    mdu_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_mdu_busy", {31'd0, mdu_busy}, 32'd0);
    check("rst_mid_mdu_count", {16'd0, stall_cycles}, 32'd0);
    set_idle();
    tick();

    // Saturation of the stall counter
    do_reset();
    rs_ID = 5'd3; id_uses_rs = 1'b1;
    WriteDestination_EX = 5'd3; ex_regwrite = 1'b1; ex_load = 1'b1;
    for (int c = 0; c < 65534; c++) tick();
    check("sat_minus_one", {16'd0, stall_cycles}, 32'hFFFE);
    for (int c = 0; c < 7; c++) tick();
    check("sat_hold", {16'd0, stall_cycles}, 32'hFFFF);
    set_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
